mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives a multi-cycle data-memory port over a req/ack handshake. Stalls the upstream pipeline while a load or store is outstanding, aborts on timeout or misalignment, and registers the results into the MEM/WB stage outputs. Sits between the EX/MEM register and the writeback stage.

## Interface
- TIMEOUT, 16: BUSY cycles without ack before abort; legal range 1..255.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- ALUout_i  input  32  EX/MEM ALU result; byte address for memory ops.
- WD_i  input  32  EX/MEM store data.
- RD_i  input  5  EX/MEM destination register.
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  input  1 each  EX/MEM control bits.
- stall_o  output  1  hold EX/MEM and earlier stages this cycle (combinational).
- mem_req_o  output  1  memory request, high throughout BUSY.
- mem_we_o  output  1  1 = write, 0 = read; valid while mem_req_o.
- mem_addr_o  output  32  word-aligned address, latched.
- mem_wdata_o  output  32  store data, latched.
- mem_ack_i  input  1  memory completion; sampled only in BUSY.
- mem_rdata_i  input  32  read data, valid with mem_ack_i on reads.
- ALUout_o, ReadData_o  output  32 each  MEM/WB registered ALU result and load data.
- RD_o  output  5  MEM/WB destination register.
- RegWrite_o, MemtoReg_o  output  1 each  MEM/WB control.
- err_o  output  1  registered one-cycle pulse on misalignment or timeout.

## Operation
- States: IDLE, BUSY. Access = MemRead_i | MemWrite_i. MemRead_i and MemWrite_i both high: treat as write.
- IDLE, no access: MEM/WB outputs load from inputs every edge (ReadData_o <= 0), stall_o = 0.
- IDLE, access, ALUout_i[1:0] != 0: no request; stall_o = 0; MEM/WB loads a bubble (RegWrite_o=0, MemtoReg_o=0, RD_o=0, data 0); err_o pulses next cycle.
- IDLE, aligned access: stall_o = 1; edge latches mem_addr_o = ALUout_i, mem_wdata_o = WD_i, mem_we_o = MemWrite_i, plus RD/RegWrite/MemtoReg/ALUout; counter cleared; go BUSY; MEM/WB loads bubble.
- BUSY, mem_ack_i = 0: stall_o = 1; counter += 1; MEM/WB loads bubble.
- BUSY, mem_ack_i = 1: stall_o = 0; edge loads MEM/WB from latched values, ReadData_o <= mem_rdata_i (reads) or 0 (writes); go IDLE.
- BUSY, counter == TIMEOUT-1 with no ack: stall_o = 0; edge aborts: MEM/WB bubble, err_o pulse, go IDLE. Ack in same cycle wins over timeout.
- mem_ack_i in IDLE ignored.
- Counter 8 bits, saturating never reached (abort first).

## Timing
- Reset (async): state IDLE, counter 0, mem_req_o/mem_we_o/err_o 0, mem_addr_o/mem_wdata_o 0, all MEM/WB outputs 0. Reset mid-BUSY drops mem_req_o immediately; memory side must discard the transaction.
- mem_req_o rises one cycle after the access appears; addr/data/we stable until the ack edge.
- Ack on k-th BUSY cycle (k >= 1): stall_o high for k cycles total; MEM/WB valid the cycle after ack.
- Non-memory instructions: one-cycle latency, zero stall.
- Upstream must hold EX/MEM inputs stable while stall_o = 1; block samples them only in IDLE.

## Test plan
- Reset mid-BUSY (rst_i high while mem_req_o=1) -> mem_req_o, stall_o, all outputs 0 same cycle; IDLE after release.
- ALU op RD=5, ALUout=0x1234, RegWrite=1 -> next cycle RegWrite_o=1, RD_o=5, ALUout_o=0x1234, stall_o never high.
- Load addr 0x100, RD=7, ack on 3rd BUSY cycle with rdata 0xDEADBEEF -> stall_o high 3 cycles, mem_addr_o=0x100, then ReadData_o=0xDEADBEEF, RD_o=7, MemtoReg_o=1.
- Store addr 0x200 data 0xCAFE, zero-wait ack -> stall 1 cycle, mem_we_o=1, mem_wdata_o=0xCAFE, RegWrite_o=0.
- Load addr 0x102 -> no mem_req_o, err_o pulse, RegWrite_o=0, no stall.
- TIMEOUT=4, load never acked -> stall 4 cycles, mem_req_o drops, err_o pulse, bubble in MEM/WB; ack on 4th cycle instead -> normal completion, no err_o.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives a multi-cycle req/ack data-memory port from
// the EX/MEM register, stalls upstream while an access is outstanding, aborts
// on misalignment or timeout, and registers results into MEM/WB outputs.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] WD_i,
    input  logic [4:0]  RD_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] ALUout_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RD_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic        err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  cnt_r;
    logic        cnt_inc_s;
    logic        latch_s;
    logic        stall_s;
    logic        err_next_s;

    // Control bits captured at request time; the latched ALU result is
    // mem_addr_o itself, since an aligned access uses ALUout_i unchanged.
    logic [4:0]  lat_rd_r;
    logic        lat_regwrite_r;
    logic        lat_memtoreg_r;

    logic [31:0] wb_aluout_s;
    logic [31:0] wb_readdata_s;
    logic [4:0]  wb_rd_s;
    logic        wb_regwrite_s;
    logic        wb_memtoreg_s;

    logic        access_s;
    logic        misaligned_s;

    assign access_s     = MemRead_i | MemWrite_i;
    assign misaligned_s = (ALUout_i[1:0] != 2'b00);
    assign mem_req_o    = (state_r == BUSY);
    // Reset forces the stall low immediately so upstream is released with it.
    assign stall_o      = stall_s & ~rst_i;

    // Next-state, stall and MEM/WB next-value selection.
    always_comb begin
        next_state_s  = state_r;
        stall_s       = 1'b0;
        latch_s       = 1'b0;
        cnt_inc_s     = 1'b0;
        err_next_s    = 1'b0;
        wb_aluout_s   = 32'h0000_0000;
        wb_readdata_s = 32'h0000_0000;
        wb_rd_s       = 5'd0;
        wb_regwrite_s = 1'b0;
        wb_memtoreg_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!access_s) begin
                    wb_aluout_s   = ALUout_i;
                    wb_rd_s       = RD_i;
                    wb_regwrite_s = RegWrite_i;
                    wb_memtoreg_s = MemtoReg_i;
                end else if (misaligned_s) begin
                    err_next_s = 1'b1;
                end else begin
                    stall_s      = 1'b1;
                    latch_s      = 1'b1;
                    next_state_s = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    wb_aluout_s   = mem_addr_o;
                    wb_readdata_s = mem_we_o ? 32'h0000_0000 : mem_rdata_i;
                    wb_rd_s       = lat_rd_r;
                    wb_regwrite_s = lat_regwrite_r;
                    wb_memtoreg_s = lat_memtoreg_r;
                    next_state_s  = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    err_next_s   = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    stall_s   = 1'b1;
                    cnt_inc_s = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, wait counter and request latches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            cnt_r          <= 8'd0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= 32'h0000_0000;
            mem_wdata_o    <= 32'h0000_0000;
            lat_rd_r       <= 5'd0;
            lat_regwrite_r <= 1'b0;
            lat_memtoreg_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                cnt_r          <= 8'd0;
                mem_we_o       <= MemWrite_i;
                mem_addr_o     <= ALUout_i;
                mem_wdata_o    <= WD_i;
                lat_rd_r       <= RD_i;
                lat_regwrite_r <= RegWrite_i;
                lat_memtoreg_r <= MemtoReg_i;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

    // MEM/WB pipeline register and error pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ALUout_o   <= 32'h0000_0000;
            ReadData_o <= 32'h0000_0000;
            RD_o       <= 5'd0;
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            ALUout_o   <= wb_aluout_s;
            ReadData_o <= wb_readdata_s;
            RD_o       <= wb_rd_s;
            RegWrite_o <= wb_regwrite_s;
            MemtoReg_o <= wb_memtoreg_s;
            err_o      <= err_next_s;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT = 4).
module tb_mem_stage_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ALUout_i, WD_i, mem_rdata_i;
    logic [4:0]  RD_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, mem_ack_i;
    logic        stall_o, mem_req_o, mem_we_o, err_o, RegWrite_o, MemtoReg_o;
    logic [31:0] mem_addr_o, mem_wdata_o, ALUout_o, ReadData_o;
    logic [4:0]  RD_o;

    int checks = 0;
    int errors = 0;

    // Values observed on the first BUSY cycle of an access.
    logic        busy_req, busy_we;
    logic [31:0] busy_addr, busy_wdata;
    int          stalls;

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUout_i(ALUout_i), .WD_i(WD_i), .RD_i(RD_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .ALUout_o(ALUout_o), .ReadData_o(ReadData_o), .RD_o(RD_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .err_o(err_o)
    );

    // Free-running 10-unit clock.
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic mr, input logic mw);
        ALUout_i = alu; WD_i = wd; RD_i = rd;
        RegWrite_i = rw; MemtoReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_ack_i = 1'b0;
    endtask

    // Runs n cycles starting from the IDLE request cycle; ack is raised on
    // BUSY cycle ack_at (0 = never). Counts stall cycles, captures BUSY values.
    task automatic run_access(input int n, input int ack_at, input logic [31:0] rdata);
        stalls = 0;
        for (int i = 0; i <= n; i++) begin
            mem_ack_i   = (ack_at != 0 && i == ack_at);
            mem_rdata_i = rdata;
            #1;
            if (stall_o) stalls++;
            if (i == 1) begin
                busy_req = mem_req_o; busy_we = mem_we_o;
                busy_addr = mem_addr_o; busy_wdata = mem_wdata_o;
            end
            if (i == n) begin
                @(posedge clk_i);
                #1;
            end else begin
                tick();
                #0;
            end
            // Back to the same phase each cycle: inputs change at edge+1.
            if (i == n) break;
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        nop();
        mem_rdata_i = 32'h0;
        #2;
        check_eq("rst_req", {31'd0, mem_req_o}, 32'd0);
        check_eq("rst_alu", ALUout_o, 32'd0);
        check_eq("rst_err", {31'd0, err_o}, 32'd0);
        check_eq("rst_addr", mem_addr_o, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // ALU op passes through with one-cycle latency and no stall.
        drive(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("alu_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check_eq("alu_rw", {31'd0, RegWrite_o}, 32'd1);
        check_eq("alu_rd", {27'd0, RD_o}, 32'd5);
        check_eq("alu_out", ALUout_o, 32'h1234);
        check_eq("alu_req", {31'd0, mem_req_o}, 32'd0);

        // Load 0x100 acked on 3rd BUSY cycle.
        drive(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        run_access(3, 3, 32'hDEADBEEF);
        nop();
        check_eq("ld_stalls", stalls, 32'd3);
        check_eq("ld_busy_req", {31'd0, busy_req}, 32'd1);
        check_eq("ld_addr", busy_addr, 32'h100);
        check_eq("ld_we", {31'd0, busy_we}, 32'd0);
        check_eq("ld_rdata", ReadData_o, 32'hDEADBEEF);
        check_eq("ld_rd", {27'd0, RD_o}, 32'd7);
        check_eq("ld_m2r", {31'd0, MemtoReg_o}, 32'd1);
        check_eq("ld_rw", {31'd0, RegWrite_o}, 32'd1);
        check_eq("ld_aluout", ALUout_o, 32'h100);
        check_eq("ld_req_after", {31'd0, mem_req_o}, 32'd0);
        check_eq("ld_err", {31'd0, err_o}, 32'd0);
        tick();

        // Store 0x200, zero-wait ack; read data must not reach ReadData_o.
        drive(32'h200, 32'hCAFE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_access(1, 1, 32'h5555_5555);
        nop();
        check_eq("st_stalls", stalls, 32'd1);
        check_eq("st_we", {31'd0, busy_we}, 32'd1);
        check_eq("st_wdata", busy_wdata, 32'hCAFE);
        check_eq("st_addr", busy_addr, 32'h200);
        check_eq("st_rw", {31'd0, RegWrite_o}, 32'd0);
        check_eq("st_rdata", ReadData_o, 32'd0);
        tick();

        // Misaligned load: no request, no stall, bubble, err pulse.
        drive(32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_eq("mis_stall", {31'd0, stall_o}, 32'd0);
        tick();
        nop();
        check_eq("mis_req", {31'd0, mem_req_o}, 32'd0);
        check_eq("mis_err", {31'd0, err_o}, 32'd1);
        check_eq("mis_rw", {31'd0, RegWrite_o}, 32'd0);
        check_eq("mis_rd", {27'd0, RD_o}, 32'd0);
        tick();
        check_eq("mis_err_clr", {31'd0, err_o}, 32'd0);

        // Timeout: never acked, abort after 4 stalled cycles.
        drive(32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        run_access(4, 0, 32'h0BAD_0BAD);
        nop();
        check_eq("to_stalls", stalls, 32'd4);
        check_eq("to_req", {31'd0, mem_req_o}, 32'd0);
        check_eq("to_err", {31'd0, err_o}, 32'd1);
        check_eq("to_rw", {31'd0, RegWrite_o}, 32'd0);
        check_eq("to_rdata", ReadData_o, 32'd0);
        tick();
        check_eq("to_err_clr", {31'd0, err_o}, 32'd0);

        // Ack on the 4th BUSY cycle wins over timeout.
        drive(32'h304, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        run_access(4, 4, 32'h11223344);
        nop();
        check_eq("ack4_stalls", stalls, 32'd4);
        check_eq("ack4_err", {31'd0, err_o}, 32'd0);
        check_eq("ack4_rdata", ReadData_o, 32'h11223344);
        check_eq("ack4_rd", {27'd0, RD_o}, 32'd4);
        tick();

        // Reset while BUSY drops request and stall at once.
        drive(32'h400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_eq("mid_req_busy", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check_eq("mid_req", {31'd0, mem_req_o}, 32'd0);
        check_eq("mid_stall", {31'd0, stall_o}, 32'd0);
        check_eq("mid_addr", mem_addr_o, 32'd0);
        check_eq("mid_alu", ALUout_o, 32'd0);
        tick();
        rst_i = 1'b0;
        drive(32'h55, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("post_stall", {31'd0, stall_o}, 32'd0);
        tick();
        check_eq("post_alu", ALUout_o, 32'h55);
        check_eq("post_rd", {27'd0, RD_o}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
